mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port memory bus between the core's three memory channels: instruction read, data read and data write.
- Captures every request the core presents in a non-stalled cycle and serialises them onto the bus in priority order.
- Holds MEM_WAIT high until all captured requests finish, then returns read results in the first unstalled cycle.
- Includes an ack-timeout watchdog that records bus errors.

Parameters:
TIMEOUT_CYCLES, 256, cycles to wait for BUS_ACK before forcing completion; 0 disables the watchdog.

Ports:
CLK  in  1  clock.
RST  in  1  asynchronous, active-low reset.
INST_RDEN  in  1  instruction read request.
INST_RIADDR  in  32  instruction read address.
INST_ROADDR  out  32  address of the returned instruction.
INST_RVALID  out  1  instruction data valid, one-cycle pulse.
INST_RDATA  out  32  instruction data.
DATA_RDEN  in  1  data read request.
DATA_RIADDR  in  32  data read address.
DATA_ROADDR  out  32  address of the returned data.
DATA_RVALID  out  1  data read valid, one-cycle pulse.
DATA_RDATA  out  32  read data.
DATA_WREN  in  1  data write request (full word).
DATA_WADDR  in  32  write address.
DATA_WDATA  in  32  write data.
MEM_WAIT  out  1  pipeline stall to the core.
BUS_REQ  out  1  bus transaction request.
BUS_WE  out  1  1 = write, 0 = read.
BUS_ADDR  out  32  bus address.
BUS_WDATA  out  32  bus write data.
BUS_ACK  in  1  transaction complete, one-cycle pulse.
BUS_RDATA  in  32  read data, valid with BUS_ACK.
BUS_ERR  out  1  sticky timeout flag.
BUS_ERR_ADDR  out  32  address of the first timed-out transaction.

Behaviour:
- Reset (RST low, asynchronous): state IDLE; all pending flags cleared.
  - All outputs 0: MEM_WAIT, BUS_REQ, BUS_WE, *_RVALID, BUS_ERR, and all address/data outputs.
  - BUS_REQ drops immediately, even mid-transaction.
  - After reset release, the first edge behaves as IDLE.
- Capture: when MEM_WAIT=0 (state IDLE or DONE), each asserted request is latched on the clock edge into its pending register.
  - Pending registers: pend_w{addr,data}, pend_dr{addr}, pend_ir{addr}.
  - Requests asserted while MEM_WAIT=1 are ignored; the stalled core re-presents them.
- States:
  - IDLE: MEM_WAIT=0, BUS_REQ=0. If any request is captured, go to the highest-priority bus state, else stay.
  - WRITE, DREAD, IREAD (bus states): BUS_REQ=1; BUS_WE/ADDR/WDATA driven from the pending register; MEM_WAIT=1.
  - DONE: MEM_WAIT=0, BUS_REQ=0. INST_RVALID and/or DATA_RVALID pulse for one cycle, only for reads completed in this batch. Next state is a bus state if new requests were captured this cycle, else IDLE.
- Priority: WRITE > DREAD > IREAD (data is the older pipeline stage).
- Bus handshake:
  - BUS_REQ/ADDR/WE/WDATA stay stable until BUS_ACK is sampled high.
  - On ack: capture BUS_RDATA for reads and clear that pending flag.
  - If another flag is pending, switch directly to the next bus state; BUS_REQ stays high with the new address (back-to-back).
  - Otherwise go to DONE.
- Latency: one request with a same-cycle ack is accepted in cycle N, on the bus in N+1, and returns RVALID in N+2.
  - MEM_WAIT is registered and high exactly for the bus-state cycles.
- Result outputs: ROADDR/RDATA are loaded on ack and held stable until the next load; only RVALID pulses.
- Watchdog (TIMEOUT_CYCLES>0):
  - A counter resets on entry to each bus state and increments each cycle without ack.
  - When it reaches TIMEOUT_CYCLES-1 with no ack, the transaction is forced complete; reads return 0.
  - BUS_ERR is set (sticky until reset); BUS_ERR_ADDR is latched only if BUS_ERR was 0.
  - A real ack in the same cycle as the timeout wins: no error.
- BUS_ACK sampled outside a bus state is ignored.

Test Plan:
- Reset with RST low mid-WRITE (BUS_REQ=1) -> BUS_REQ and MEM_WAIT go to 0 asynchronously; after release, state is IDLE and no RVALID appears.
- INST_RDEN=1, addr 0x100, in cycle N; bus acks immediately with 0x00000013 -> BUS_REQ=1 with BUS_ADDR=0x100 in N+1; MEM_WAIT=1 only in N+1; INST_RVALID=1 with ROADDR=0x100 and RDATA=0x13 in N+2.
- Write 0x2000/0xDEADBEEF, data read 0x3000 and instruction read 0x104 all in one cycle, ack 1 cycle after each request -> bus order W (BUS_WE=1), DR, IR, back-to-back; MEM_WAIT high throughout; both RVALIDs pulse together in DONE; DATA_RDATA equals the 0x3000 ack data.
- Ack delayed 5 cycles on a read -> BUS_ADDR and BUS_REQ stable for 6 cycles; inputs asserted during MEM_WAIT produce no extra bus transaction.
- TIMEOUT_CYCLES=4, no ack, read at 0xBAD0 -> forced completion after 4 bus cycles; DATA_RDATA=0; BUS_ERR=1 and BUS_ERR_ADDR=0xBAD0. A second timeout at 0xBAD4 leaves BUS_ERR_ADDR at 0xBAD0.
- New INST_RDEN asserted in the DONE cycle -> captured; IREAD entered next cycle without passing through IDLE.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Signal bundle between the core memory ports, the arbiter and the shared bus.
// The slave view belongs to the arbiter; master is the view of its environment.
interface mem_arbiter_if;
    logic        INST_RDEN;
    logic [31:0] INST_RIADDR;
    logic [31:0] INST_ROADDR;
    logic        INST_RVALID;
    logic [31:0] INST_RDATA;
    logic        DATA_RDEN;
    logic [31:0] DATA_RIADDR;
    logic [31:0] DATA_ROADDR;
    logic        DATA_RVALID;
    logic [31:0] DATA_RDATA;
    logic        DATA_WREN;
    logic [31:0] DATA_WADDR;
    logic [31:0] DATA_WDATA;
    logic        MEM_WAIT;
    logic        BUS_REQ;
    logic        BUS_WE;
    logic [31:0] BUS_ADDR;
    logic [31:0] BUS_WDATA;
    logic        BUS_ACK;
    logic [31:0] BUS_RDATA;
    logic        BUS_ERR;
    logic [31:0] BUS_ERR_ADDR;

    modport slave (
        input  INST_RDEN, INST_RIADDR, DATA_RDEN, DATA_RIADDR,
        input  DATA_WREN, DATA_WADDR, DATA_WDATA, BUS_ACK, BUS_RDATA,
        output INST_ROADDR, INST_RVALID, INST_RDATA,
        output DATA_ROADDR, DATA_RVALID, DATA_RDATA, MEM_WAIT,
        output BUS_REQ, BUS_WE, BUS_ADDR, BUS_WDATA, BUS_ERR, BUS_ERR_ADDR
    );

    modport master (
        output INST_RDEN, INST_RIADDR, DATA_RDEN, DATA_RIADDR,
        output DATA_WREN, DATA_WADDR, DATA_WDATA, BUS_ACK, BUS_RDATA,
        input  INST_ROADDR, INST_RVALID, INST_RDATA,
        input  DATA_ROADDR, DATA_RVALID, DATA_RDATA, MEM_WAIT,
        input  BUS_REQ, BUS_WE, BUS_ADDR, BUS_WDATA, BUS_ERR, BUS_ERR_ADDR
    );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises instruction-read, data-read and data-write requests onto one
// single-port bus (write > data read > instruction read) with an ack watchdog.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic         CLK,
    input  logic         RST,
    mem_arbiter_if.slave io
);
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_DREAD, S_IREAD, S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic        pw_q, pw_d, pdr_q, pdr_d, pir_q, pir_d;
    logic [31:0] waddr_q, waddr_d, wdata_q, wdata_d;
    logic [31:0] draddr_q, draddr_d, iraddr_q, iraddr_d;
    logic        ib_q, ib_d, db_q, db_d;
    logic [31:0] cnt_q, cnt_d;
    logic        mem_wait_q, mem_wait_d, bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
    logic        irvalid_q, irvalid_d, drvalid_q, drvalid_d;
    logic [31:0] iroaddr_q, iroaddr_d, irdata_q, irdata_d;
    logic [31:0] droaddr_q, droaddr_d, drdata_q, drdata_d;
    logic        err_q, err_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic        tmo, ack;

    function automatic state_e pick(input logic w, input logic dr,
                                    input logic ir, input state_e none);
        if (w)       return S_WRITE;
        else if (dr) return S_DREAD;
        else if (ir) return S_IREAD;
        return none;
    endfunction

    always_comb begin
        state_d   = state_q;
        pw_d      = pw_q;
        pdr_d     = pdr_q;
        pir_d     = pir_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        draddr_d  = draddr_q;
        iraddr_d  = iraddr_q;
        ib_d      = ib_q;
        db_d      = db_q;
        cnt_d     = cnt_q;
        irvalid_d = 1'b0;
        drvalid_d = 1'b0;
        iroaddr_d = iroaddr_q;
        irdata_d  = irdata_q;
        droaddr_d = droaddr_q;
        drdata_d  = drdata_q;
        err_d     = err_q;
        err_addr_d = err_addr_q;
        tmo       = 1'b0;
        ack       = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                pw_d  = io.DATA_WREN;
                pdr_d = io.DATA_RDEN;
                pir_d = io.INST_RDEN;
                if (io.DATA_WREN) begin
                    waddr_d = io.DATA_WADDR;
                    wdata_d = io.DATA_WDATA;
                end
                if (io.DATA_RDEN) draddr_d = io.DATA_RIADDR;
                if (io.INST_RDEN) iraddr_d = io.INST_RIADDR;
                ib_d    = 1'b0;
                db_d    = 1'b0;
                cnt_d   = '0;
                state_d = pick(pw_d, pdr_d, pir_d, S_IDLE);
            end
            S_WRITE, S_DREAD, S_IREAD: begin
                // a real ack in the final watchdog cycle takes precedence
                tmo = (TIMEOUT_CYCLES != 0) && !io.BUS_ACK &&
                      (cnt_q == TIMEOUT_CYCLES - 1);
                ack   = io.BUS_ACK || tmo;
                cnt_d = cnt_q + 32'd1;
                if (ack) begin
                    cnt_d = '0;
                    if (state_q == S_WRITE) pw_d = 1'b0;
                    if (state_q == S_DREAD) begin
                        pdr_d     = 1'b0;
                        db_d      = 1'b1;
                        droaddr_d = draddr_q;
                        drdata_d  = tmo ? 32'h0 : io.BUS_RDATA;
                    end
                    if (state_q == S_IREAD) begin
                        pir_d     = 1'b0;
                        ib_d      = 1'b1;
                        iroaddr_d = iraddr_q;
                        irdata_d  = tmo ? 32'h0 : io.BUS_RDATA;
                    end
                    if (tmo) begin
                        err_d = 1'b1;
                        if (!err_q) err_addr_d = bus_addr_q;
                    end
                    state_d = pick(pw_d, pdr_d, pir_d, S_DONE);
                    if (state_d == S_DONE) begin
                        irvalid_d = ib_d;
                        drvalid_d = db_d;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        bus_req_d   = (state_d == S_WRITE) || (state_d == S_DREAD) ||
                      (state_d == S_IREAD);
        mem_wait_d  = bus_req_d;
        bus_we_d    = (state_d == S_WRITE);
        bus_wdata_d = bus_we_d ? wdata_d : 32'h0;
        bus_addr_d  = 32'h0;
        if (state_d == S_WRITE) bus_addr_d = waddr_d;
        if (state_d == S_DREAD) bus_addr_d = draddr_d;
        if (state_d == S_IREAD) bus_addr_d = iraddr_d;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            pw_q        <= 1'b0;
            pdr_q       <= 1'b0;
            pir_q       <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            draddr_q    <= '0;
            iraddr_q    <= '0;
            ib_q        <= 1'b0;
            db_q        <= 1'b0;
            cnt_q       <= '0;
            mem_wait_q  <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            irvalid_q   <= 1'b0;
            drvalid_q   <= 1'b0;
            iroaddr_q   <= '0;
            irdata_q    <= '0;
            droaddr_q   <= '0;
            drdata_q    <= '0;
            err_q       <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            pw_q        <= pw_d;
            pdr_q       <= pdr_d;
            pir_q       <= pir_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            draddr_q    <= draddr_d;
            iraddr_q    <= iraddr_d;
            ib_q        <= ib_d;
            db_q        <= db_d;
            cnt_q       <= cnt_d;
            mem_wait_q  <= mem_wait_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            irvalid_q   <= irvalid_d;
            drvalid_q   <= drvalid_d;
            iroaddr_q   <= iroaddr_d;
            irdata_q    <= irdata_d;
            droaddr_q   <= droaddr_d;
            drdata_q    <= drdata_d;
            err_q       <= err_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign io.MEM_WAIT     = mem_wait_q;
    assign io.BUS_REQ      = bus_req_q;
    assign io.BUS_WE       = bus_we_q;
    assign io.BUS_ADDR     = bus_addr_q;
    assign io.BUS_WDATA    = bus_wdata_q;
    assign io.INST_RVALID  = irvalid_q;
    assign io.INST_ROADDR  = iroaddr_q;
    assign io.INST_RDATA   = irdata_q;
    assign io.DATA_RVALID  = drvalid_q;
    assign io.DATA_ROADDR  = droaddr_q;
    assign io.DATA_RDATA   = drdata_q;
    assign io.BUS_ERR      = err_q;
    assign io.BUS_ERR_ADDR = err_addr_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized batches
// against a memory-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if io ();
    mem_arbiter_if io_t ();

    mem_arbiter dut (.CLK(clk), .RST(rst_n), .io(io));
    mem_arbiter #(.TIMEOUT_CYCLES(4)) dut_t (.CLK(clk), .RST(rst_n), .io(io_t));

    int checks = 0;
    int errors = 0;

    bit resp_en = 1'b1;
    bit rand_dly = 1'b0;
    int fix_dly = 0;
    int wait_cnt = 0;
    int cur_dly = 0;
    int dly_sum = 0;
    logic [64:0] bus_log[$];
    logic [31:0] smem[logic [31:0]];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        return smem.exists(a) ? smem[a] : dflt(a);
    endfunction

    // bus slave for the main instance: ack after cur_dly waiting cycles
    always @(negedge clk) begin
        if (io.BUS_ACK === 1'b1) wait_cnt = 0;
        if (resp_en && io.BUS_REQ === 1'b1) begin
            if (wait_cnt == 0)
                cur_dly = rand_dly ? int'($urandom_range(0, 3)) : fix_dly;
            if (wait_cnt == cur_dly) begin
                io.BUS_ACK = 1'b1;
                io.BUS_RDATA = io.BUS_WE ? 32'h0 : slave_rd(io.BUS_ADDR);
                if (io.BUS_WE) smem[io.BUS_ADDR] = io.BUS_WDATA;
                bus_log.push_back({io.BUS_WE, io.BUS_ADDR,
                                   io.BUS_WE ? io.BUS_WDATA : 32'h0});
                dly_sum += cur_dly + 1;
            end else begin
                io.BUS_ACK = 1'b0;
                wait_cnt++;
            end
        end else begin
            io.BUS_ACK = 1'b0;
            io.BUS_RDATA = 32'h0;
            wait_cnt = 0;
        end
    end

    task automatic drive(input bit w, input bit dr, input bit ir,
                         input logic [31:0] wa, input logic [31:0] wd,
                         input logic [31:0] da, input logic [31:0] ia);
        io.DATA_WREN = w;
        io.DATA_WADDR = wa;
        io.DATA_WDATA = wd;
        io.DATA_RDEN = dr;
        io.DATA_RIADDR = da;
        io.INST_RDEN = ir;
        io.INST_RIADDR = ia;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({io.MEM_WAIT, io.BUS_REQ, io.BUS_WE, io.INST_RVALID,
             io.DATA_RVALID, io.BUS_ERR} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 0", {io.MEM_WAIT,
                     io.BUS_REQ, io.BUS_WE, io.INST_RVALID,
                     io.DATA_RVALID, io.BUS_ERR});
        end
        checks++;
        if ({io.BUS_ADDR, io.BUS_WDATA, io.INST_ROADDR, io.INST_RDATA,
             io.DATA_ROADDR, io.DATA_RDATA, io.BUS_ERR_ADDR} !== '0) begin
            errors++;
            $display("FAIL reset_words got nonzero exp 0");
        end
        @(negedge clk);
        rst_n = 1'b1;
        resp_en = 1'b0;
        drive(1, 0, 0, 32'h2000, 32'h1111_2222, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({io.BUS_REQ, io.BUS_WE, io.MEM_WAIT} !== 3'b111) begin
            errors++;
            $display("FAIL rst_pre_write got %b exp 111",
                     {io.BUS_REQ, io.BUS_WE, io.MEM_WAIT});
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({io.BUS_REQ, io.MEM_WAIT, io.BUS_WE} !== 3'b000) begin
            errors++;
            $display("FAIL rst_async got %b exp 000",
                     {io.BUS_REQ, io.MEM_WAIT, io.BUS_WE});
        end
        @(negedge clk);
        rst_n = 1'b1;
        resp_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({io.INST_RVALID, io.DATA_RVALID, io.BUS_REQ,
                 io.MEM_WAIT} !== 4'b0) begin
                errors++;
                $display("FAIL rst_after c=%0d got %b exp 0000", c,
                         {io.INST_RVALID, io.DATA_RVALID, io.BUS_REQ,
                          io.MEM_WAIT});
            end
        end
        bus_log.delete();
    endtask

    task automatic test_latency();
        fix_dly = 0;
        smem[32'h100] = 32'h0000_0013;
        @(negedge clk);
        drive(0, 0, 1, 0, 0, 0, 32'h100);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({io.BUS_REQ, io.MEM_WAIT, io.BUS_WE, io.BUS_ADDR} !==
            {3'b110, 32'h100}) begin
            errors++;
            $display("FAIL lat_bus got %b/%h exp 110/00000100",
                     {io.BUS_REQ, io.MEM_WAIT, io.BUS_WE}, io.BUS_ADDR);
        end
        @(negedge clk);
        checks++;
        if ({io.INST_RVALID, io.DATA_RVALID, io.MEM_WAIT, io.BUS_REQ,
             io.INST_ROADDR, io.INST_RDATA} !==
            {4'b1000, 32'h100, 32'h13}) begin
            errors++;
            $display("FAIL lat_ret got %b %h %h exp 1000 100 13",
                     {io.INST_RVALID, io.DATA_RVALID, io.MEM_WAIT,
                      io.BUS_REQ}, io.INST_ROADDR, io.INST_RDATA);
        end
        @(negedge clk);
        checks++;
        if ({io.INST_RVALID, io.MEM_WAIT} !== 2'b00) begin
            errors++;
            $display("FAIL lat_pulse got %b exp 00",
                     {io.INST_RVALID, io.MEM_WAIT});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ea;
        fix_dly = 1;
        smem[32'h3000] = 32'hCAFE_0001;
        smem[32'h104] = 32'h0040_0093;
        @(negedge clk);
        drive(1, 1, 1, 32'h2000, 32'hDEAD_BEEF, 32'h3000, 32'h104);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) drive(0, 0, 0, 0, 0, 0, 0);
            ea = (c < 2) ? 32'h2000 : (c < 4) ? 32'h3000 : 32'h104;
            checks++;
            if ({io.BUS_REQ, io.MEM_WAIT, io.BUS_WE, io.BUS_ADDR} !==
                {2'b11, c < 2, ea}) begin
                errors++;
                $display("FAIL b2b_bus c=%0d got %b/%h exp we=%0d %h", c,
                         {io.BUS_REQ, io.MEM_WAIT, io.BUS_WE}, io.BUS_ADDR,
                         c < 2, ea);
            end
            if (c < 2) begin
                checks++;
                if (io.BUS_WDATA !== 32'hDEAD_BEEF) begin
                    errors++;
                    $display("FAIL b2b_wdata got %h exp deadbeef",
                             io.BUS_WDATA);
                end
            end
        end
        @(negedge clk);
        checks++;
        if ({io.INST_RVALID, io.DATA_RVALID, io.MEM_WAIT,
             io.BUS_REQ} !== 4'b1100) begin
            errors++;
            $display("FAIL b2b_done got %b exp 1100", {io.INST_RVALID,
                     io.DATA_RVALID, io.MEM_WAIT, io.BUS_REQ});
        end
        checks++;
        if ({io.DATA_ROADDR, io.DATA_RDATA, io.INST_ROADDR, io.INST_RDATA}
            !== {32'h3000, 32'hCAFE_0001, 32'h104, 32'h0040_0093}) begin
            errors++;
            $display("FAIL b2b_data got %h %h %h %h", io.DATA_ROADDR,
                     io.DATA_RDATA, io.INST_ROADDR, io.INST_RDATA);
        end
        bus_log.delete();
    endtask

    task automatic test_ack_delay();
        logic [31:0] exp_d;
        fix_dly = 5;
        exp_d = dflt(32'h4000);
        @(negedge clk);
        drive(0, 1, 0, 0, 0, 32'h4000, 0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) drive(1, 0, 1, 32'h5000, 32'h5, 0, 32'h6000);
            if (c == 4) drive(0, 0, 0, 0, 0, 0, 0);
            checks++;
            if ({io.BUS_REQ, io.MEM_WAIT, io.BUS_ADDR} !==
                {2'b11, 32'h4000}) begin
                errors++;
                $display("FAIL dly_stable c=%0d got %b/%h exp 11/4000", c,
                         {io.BUS_REQ, io.MEM_WAIT}, io.BUS_ADDR);
            end
        end
        @(negedge clk);
        checks++;
        if ({io.DATA_RVALID, io.INST_RVALID, io.MEM_WAIT, io.DATA_RDATA}
            !== {3'b100, exp_d}) begin
            errors++;
            $display("FAIL dly_done got %b %h exp 100 %h", {io.DATA_RVALID,
                     io.INST_RVALID, io.MEM_WAIT}, io.DATA_RDATA, exp_d);
        end
        @(negedge clk);
        checks++;
        if ({io.BUS_REQ, io.MEM_WAIT} !== 2'b00 || bus_log.size() != 1)
        begin
            errors++;
            $display("FAIL dly_extra got req=%b n=%0d exp 0 1",
                     io.BUS_REQ, bus_log.size());
        end
        bus_log.delete();
        fix_dly = 0;
    endtask

    task automatic test_done_capture();
        fix_dly = 0;
        @(negedge clk);
        drive(0, 0, 1, 0, 0, 0, 32'h200);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({io.INST_RVALID, io.MEM_WAIT, io.INST_ROADDR} !==
            {2'b10, 32'h200}) begin
            errors++;
            $display("FAIL dc_first got %b %h exp 10 200",
                     {io.INST_RVALID, io.MEM_WAIT}, io.INST_ROADDR);
        end
        drive(0, 0, 1, 0, 0, 0, 32'h204);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({io.BUS_REQ, io.MEM_WAIT, io.BUS_ADDR} !== {2'b11, 32'h204})
        begin
            errors++;
            $display("FAIL dc_iread got %b %h exp 11 204",
                     {io.BUS_REQ, io.MEM_WAIT}, io.BUS_ADDR);
        end
        @(negedge clk);
        checks++;
        if ({io.INST_RVALID, io.INST_ROADDR, io.INST_RDATA} !==
            {1'b1, 32'h204, dflt(32'h204)}) begin
            errors++;
            $display("FAIL dc_second got %b %h %h exp 1 204 %h",
                     io.INST_RVALID, io.INST_ROADDR, io.INST_RDATA,
                     dflt(32'h204));
        end
        bus_log.delete();
    endtask

    task automatic test_timeout();
        logic [31:0] ta[3] = '{32'hC000, 32'hBAD0, 32'hBAD4};
        logic [31:0] td[3] = '{32'h77, 32'h0, 32'h0};
        logic        te[3] = '{1'b0, 1'b1, 1'b1};
        logic [31:0] tea[3] = '{32'h0, 32'hBAD0, 32'hBAD0};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            io_t.DATA_RDEN = 1'b1;
            io_t.DATA_RIADDR = ta[k];
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                io_t.DATA_RDEN = 1'b0;
                checks++;
                if ({io_t.BUS_REQ, io_t.MEM_WAIT, io_t.BUS_ADDR} !==
                    {2'b11, ta[k]}) begin
                    errors++;
                    $display("FAIL tmo_bus k=%0d c=%0d got %b %h", k, c,
                             {io_t.BUS_REQ, io_t.MEM_WAIT}, io_t.BUS_ADDR);
                end
                if (k == 0 && c == 3) begin
                    io_t.BUS_ACK = 1'b1;
                    io_t.BUS_RDATA = 32'h77;
                end
            end
            @(negedge clk);
            io_t.BUS_ACK = 1'b0;
            io_t.BUS_RDATA = 32'h0;
            checks++;
            if ({io_t.DATA_RVALID, io_t.BUS_REQ, io_t.DATA_ROADDR,
                 io_t.DATA_RDATA} !== {2'b10, ta[k], td[k]}) begin
                errors++;
                $display("FAIL tmo_done k=%0d got %b %h %h exp 10 %h %h",
                         k, {io_t.DATA_RVALID, io_t.BUS_REQ},
                         io_t.DATA_ROADDR, io_t.DATA_RDATA, ta[k], td[k]);
            end
            checks++;
            if (io_t.BUS_ERR !== te[k] ||
                (te[k] && io_t.BUS_ERR_ADDR !== tea[k])) begin
                errors++;
                $display("FAIL tmo_err k=%0d got %b %h exp %b %h", k,
                         io_t.BUS_ERR, io_t.BUS_ERR_ADDR, te[k], tea[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rmem[logic [31:0]];
        logic [64:0] expq[$];
        bit w, dr, ir, ki, kd;
        logic [31:0] wa, wd, da, ia, ei_a, ei_d, ed_a, ed_d;
        int waits;
        ki = 0;
        kd = 0;
        ei_a = 0; ei_d = 0; ed_a = 0; ed_d = 0;
        rand_dly = 1'b1;
        @(negedge clk);
        for (int it = 0; it < 25; it++) begin
            w = 1'($urandom);
            dr = 1'($urandom);
            ir = 1'($urandom);
            if (!w && !dr && !ir) ir = 1'b1;
            wa = 32'h8000 + 4 * $urandom_range(0, 7);
            da = 32'h8000 + 4 * $urandom_range(0, 7);
            ia = 32'h8000 + 4 * $urandom_range(0, 7);
            wd = $urandom;
            expq.delete();
            if (w) begin
                rmem[wa] = wd;
                expq.push_back({1'b1, wa, wd});
            end
            if (dr) begin
                ed_a = da;
                ed_d = rmem.exists(da) ? rmem[da] : dflt(da);
                kd = 1'b1;
                expq.push_back({1'b0, da, 32'h0});
            end
            if (ir) begin
                ei_a = ia;
                ei_d = rmem.exists(ia) ? rmem[ia] : dflt(ia);
                ki = 1'b1;
                expq.push_back({1'b0, ia, 32'h0});
            end
            bus_log.delete();
            dly_sum = 0;
            waits = 0;
            drive(w, dr, ir, wa, wd, da, ia);
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (k == 0) drive(0, 0, 0, 0, 0, 0, 0);
                if (io.MEM_WAIT !== 1'b1) break;
                waits++;
            end
            checks++;
            if (io.MEM_WAIT !== 1'b0 || waits != dly_sum) begin
                errors++;
                $display("FAIL rnd_wait it=%0d got %0d exp %0d", it, waits,
                         dly_sum);
            end
            checks++;
            if ({io.INST_RVALID, io.DATA_RVALID} !== {ir, dr}) begin
                errors++;
                $display("FAIL rnd_valid it=%0d got %b exp %b", it,
                         {io.INST_RVALID, io.DATA_RVALID}, {ir, dr});
            end
            checks++;
            if (bus_log.size() != expq.size()) begin
                errors++;
                $display("FAIL rnd_nbus it=%0d got %0d exp %0d", it,
                         bus_log.size(), expq.size());
            end else begin
                for (int j = 0; j < expq.size(); j++) begin
                    if (bus_log[j] !== expq[j]) begin
                        errors++;
                        $display("FAIL rnd_bus it=%0d j=%0d got %h exp %h",
                                 it, j, bus_log[j], expq[j]);
                    end
                end
            end
            if (kd) begin
                checks++;
                if ({io.DATA_ROADDR, io.DATA_RDATA} !== {ed_a, ed_d}) begin
                    errors++;
                    $display("FAIL rnd_dres it=%0d got %h %h exp %h %h", it,
                             io.DATA_ROADDR, io.DATA_RDATA, ed_a, ed_d);
                end
            end
            if (ki) begin
                checks++;
                if ({io.INST_ROADDR, io.INST_RDATA} !== {ei_a, ei_d}) begin
                    errors++;
                    $display("FAIL rnd_ires it=%0d got %h %h exp %h %h", it,
                             io.INST_ROADDR, io.INST_RDATA, ei_a, ei_d);
                end
            end
            @(negedge clk);
            checks++;
            if ({io.INST_RVALID, io.DATA_RVALID, io.MEM_WAIT,
                 io.BUS_REQ} !== 4'b0) begin
                errors++;
                $display("FAIL rnd_idle it=%0d got %b exp 0000", it,
                         {io.INST_RVALID, io.DATA_RVALID, io.MEM_WAIT,
                          io.BUS_REQ});
            end
        end
        rand_dly = 1'b0;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        io_t.INST_RDEN = 1'b0;
        io_t.INST_RIADDR = '0;
        io_t.DATA_RDEN = 1'b0;
        io_t.DATA_RIADDR = '0;
        io_t.DATA_WREN = 1'b0;
        io_t.DATA_WADDR = '0;
        io_t.DATA_WDATA = '0;
        io_t.BUS_ACK = 1'b0;
        io_t.BUS_RDATA = '0;
        test_reset();
        test_latency();
        test_back_to_back();
        test_ack_delay();
        test_done_capture();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog bench did not finish got timeout exp done");
        $fatal(1);
    end
endmodule
